// File: rtl/yd_uart_if.sv
// Core data-bus port of the memory-mapped UART: address, write data/enable,
// combinational read data and register hit.
interface yd_uart_if;
    logic [15:0] d_addr;
    logic [15:0] d_din;
    logic        d_we;
    logic [15:0] d_dout;
    logic        hit;

    modport master (output d_addr, d_din, d_we, input d_dout, hit);
    modport slave  (input d_addr, d_din, d_we, output d_dout, hit);
endinterface

// File: rtl/yd_uart.sv
// Memory-mapped 8N1 UART: DATA/STATUS/DIV registers, independent TX and RX FSMs,
// programmable clocks-per-bit divisor.
module yd_uart #(
    parameter logic [15:0] BASE    = 16'hFF00,
    parameter logic [15:0] CLK_DIV = 16'd434
) (
    input  logic       clk,
    input  logic       rst,
    yd_uart_if.slave   bus,
    input  logic       rxd,
    output logic       txd
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    typedef struct packed {
        logic frame_err;
        logic overrun;
        logic rx_valid;
        logic tx_busy;
    } status_t;

    logic [15:0] div, period, half;
    logic        sel_data, sel_stat, sel_div;
    status_t     status;

    state_t      tx_state;
    logic [15:0] tx_cnt;
    logic [7:0]  tx_sh;
    logic [2:0]  tx_bit;
    logic        tx_busy;

    state_t      rx_state;
    logic [15:0] rx_cnt;
    logic [7:0]  rx_sh;
    logic [2:0]  rx_bit;
    logic        rx_s1, rx_s2, rx_s3;
    logic        rx_valid, overrun, frame_err;
    logic [7:0]  rx_byte;

    // Divisors below 2 would leave no room for a mid-bit sample.
    assign period = (div < 16'd2) ? 16'd2 : div;
    assign half   = {1'b0, period[15:1]};

    assign sel_data = (bus.d_addr == BASE);
    assign sel_stat = (bus.d_addr == BASE + 16'd1);
    assign sel_div  = (bus.d_addr == BASE + 16'd2);
    assign bus.hit  = sel_data | sel_stat | sel_div;

    assign tx_busy = (tx_state != IDLE);
    assign status  = {frame_err, overrun, rx_valid, tx_busy};

    always_comb begin
        bus.d_dout = 16'h0;
        if (sel_data)
            bus.d_dout = {8'h0, rx_byte};
        else if (sel_stat)
            bus.d_dout = {12'h0, status};
        else if (sel_div)
            bus.d_dout = div;
    end

    always_ff @(posedge clk) begin
        if (rst)
            div <= CLK_DIV;
        else if (bus.d_we && sel_div)
            div <= bus.d_din;
    end

    // Counters reload from the live period, so a DIV write applies from the next bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= IDLE;
            txd      <= 1'b1;
            tx_cnt   <= 16'h0;
            tx_sh    <= 8'h0;
            tx_bit   <= 3'd0;
        end else begin
            if (tx_state != IDLE)
                tx_cnt <= (tx_cnt == 16'h0) ? period - 16'd1 : tx_cnt - 16'd1;
            case (tx_state)
                IDLE: begin
                    if (bus.d_we && sel_data) begin
                        tx_state <= START;
                        txd      <= 1'b0;
                        tx_sh    <= bus.d_din[7:0];
                        tx_cnt   <= period - 16'd1;
                        tx_bit   <= 3'd0;
                    end
                end
                START: begin
                    if (tx_cnt == 16'h0) begin
                        tx_state <= DATA;
                        txd      <= tx_sh[0];
                    end
                end
                DATA: begin
                    if (tx_cnt == 16'h0) begin
                        if (tx_bit == 3'd7) begin
                            tx_state <= STOP;
                            txd      <= 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            tx_sh  <= {1'b0, tx_sh[7:1]};
                            txd    <= tx_sh[1];
                        end
                    end
                end
                STOP: begin
                    if (tx_cnt == 16'h0) begin
                        tx_state <= IDLE;
                        txd      <= 1'b1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // rx_s3 is the previous synchronised sample, used only for falling-edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state  <= IDLE;
            rx_cnt    <= 16'h0;
            rx_sh     <= 8'h0;
            rx_bit    <= 3'd0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rx_byte   <= 8'h00;
        end else begin
            if (bus.d_we && sel_stat) begin
                if (bus.d_din[1]) rx_valid  <= 1'b0;
                if (bus.d_din[2]) overrun   <= 1'b0;
                if (bus.d_din[3]) frame_err <= 1'b0;
            end
            if (rx_state != IDLE && rx_cnt != 16'h0)
                rx_cnt <= rx_cnt - 16'd1;
            case (rx_state)
                IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_state <= START;
                        rx_cnt   <= half - 16'd1;
                    end
                end
                START: begin
                    if (rx_cnt == 16'h0) begin
                        if (rx_s2) begin
                            rx_state <= IDLE;
                        end else begin
                            rx_state <= DATA;
                            rx_cnt   <= period - 16'd1;
                            rx_bit   <= 3'd0;
                        end
                    end
                end
                DATA: begin
                    if (rx_cnt == 16'h0) begin
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        rx_cnt <= period - 16'd1;
                        if (rx_bit == 3'd7)
                            rx_state <= STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end
                end
                STOP: begin
                    // Placed after the W1C clears so a same-cycle set takes priority.
                    if (rx_cnt == 16'h0) begin
                        rx_state <= IDLE;
                        if (!rx_s2)
                            frame_err <= 1'b1;
                        if (rx_valid) begin
                            overrun <= 1'b1;
                        end else begin
                            rx_byte  <= rx_sh;
                            rx_valid <= 1'b1;
                        end
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_yd_uart.sv
// Self-checking bench for yd_uart: randomized TX/RX frames against a
// frame-level reference model of the register file.
module tb_yd_uart;
    localparam logic [15:0] BASE = 16'hFF00;

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    logic txd;

    yd_uart_if bus ();

    yd_uart #(.BASE(BASE), .CLK_DIV(16'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .rxd (rxd),
        .txd (txd)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int         m_div;
    logic       m_valid, m_ovr, m_ferr;
    logic [7:0] m_byte;

    function automatic int per();
        return (m_div < 2) ? 2 : m_div;
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input int i, input logic stopb);
        if (i == 0) return 1'b0;
        if (i == 9) return stopb;
        return b[i-1];
    endfunction

    function automatic logic [15:0] m_status(input logic busy);
        return {12'h0, m_ferr, m_ovr, m_valid, busy};
    endfunction

    function automatic void m_reset();
        m_div = 4; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_byte = 8'h00;
    endfunction

    function automatic void m_rx(input logic [7:0] b, input logic stopb);
        if (!stopb) m_ferr = 1'b1;
        if (m_valid) m_ovr = 1'b1;
        else begin m_byte = b; m_valid = 1'b1; end
    endfunction

    function automatic void m_w1c(input logic [15:0] d);
        if (d[1]) m_valid = 1'b0;
        if (d[2]) m_ovr = 1'b0;
        if (d[3]) m_ferr = 1'b0;
    endfunction

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.d_addr = a; bus.d_din = d; bus.d_we = 1'b1;
        @(negedge clk);
        bus.d_we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] v);
        bus.d_addr = a;
        #1;
        v = bus.d_dout;
    endtask

    task automatic set_div(input int d);
        wr(BASE + 16'd2, 16'(d));
        m_div = d;
    endtask

    task automatic send(input logic [7:0] b, input logic stopb);
        int p;
        p = per();
        for (int i = 0; i < 10; i++) begin
            rxd = frame_bit(b, i, stopb);
            repeat (p) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (p + 4) @(negedge clk);
        m_rx(b, stopb);
    endtask

    // Records txd and STATUS.tx_busy each cycle after the write; optional
    // second DATA write at cycle second_at (must be ignored while busy).
    task automatic test_tx(input logic [7:0] b, input int second_at);
        int p, nf, n;
        logic [255:0] ot, et, ob, eb;
        p = per(); nf = 10 * p;
        n = (second_at >= 0) ? 2 * nf + 3 : nf + 3;
        ot = '0; et = '0; ob = '0; eb = '0;
        wr(BASE, {8'h0, b});
        for (int k = 0; k < n; k++) begin
            et[k] = (k < nf) ? frame_bit(b, k / p, 1'b1) : 1'b1;
            eb[k] = (k < nf);
            if (k == second_at) begin
                bus.d_addr = BASE; bus.d_din = 16'h0033; bus.d_we = 1'b1;
            end else begin
                bus.d_we = 1'b0; bus.d_addr = BASE + 16'd1;
            end
            #1;
            ot[k] = txd;
            ob[k] = bus.d_dout[0];
            @(negedge clk);
        end
        bus.d_we = 1'b0;
        n_cmp++;
        if (ot !== et) begin
            n_err++;
            $display("FAIL tx_wave b=%h p=%0d got=%h want=%h", b, p, ot, et);
        end
        if (second_at < 0) begin
            n_cmp++;
            if (ob !== eb) begin
                n_err++;
                $display("FAIL tx_busy b=%h p=%0d got=%h want=%h", b, p, ob, eb);
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] v, addr, exp_dout;
        logic exp_hit;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int a = -1; a < 4; a++) begin
            addr = BASE + 16'(a);
            exp_hit = (a >= 0 && a <= 2);
            exp_dout = (a == 2) ? 16'd4 : 16'd0;
            bus.d_addr = addr;
            #1;
            n_cmp++;
            if (bus.hit !== exp_hit) begin
                n_err++; $display("FAIL rst_hit addr=%h got=%b want=%b", addr, bus.hit, exp_hit);
            end
            n_cmp++;
            if (bus.d_dout !== exp_dout) begin
                n_err++; $display("FAIL rst_dout addr=%h got=%h want=%h", addr, bus.d_dout, exp_dout);
            end
        end
        n_cmp++;
        if (txd !== 1'b1) begin n_err++; $display("FAIL rst_txd got=%b want=1", txd); end
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        rd(BASE + 16'd1, v);
        n_cmp++;
        if (v !== m_status(1'b0)) begin n_err++; $display("FAIL rst_status got=%h want=%h", v, m_status(1'b0)); end
        rd(BASE, v);
        n_cmp++;
        if (v !== {8'h0, m_byte}) begin n_err++; $display("FAIL rst_data got=%h want=%h", v, {8'h0, m_byte}); end
    endtask

    task automatic test_rx_check(input string tag);
        logic [15:0] v;
        rd(BASE, v);
        n_cmp++;
        if (v !== {8'h0, m_byte}) begin n_err++; $display("FAIL %s_data got=%h want=%h", tag, v, {8'h0, m_byte}); end
        rd(BASE + 16'd1, v);
        n_cmp++;
        if (v !== m_status(1'b0)) begin n_err++; $display("FAIL %s_status got=%h want=%h", tag, v, m_status(1'b0)); end
    endtask

    task automatic test_rx();
        logic [15:0] mask;
        set_div(4);
        send(8'h3C, 1'b1);
        test_rx_check("rx3c");
        wr(BASE + 16'd1, 16'h0002); m_w1c(16'h0002);
        test_rx_check("rx3c_w1c");
        for (int it = 0; it < 6; it++) begin
            set_div(int'($urandom_range(0, 7)));
            send(8'($urandom), $urandom_range(0, 3) != 0);
            test_rx_check("rx_rand");
            mask = 16'($urandom_range(0, 15));
            wr(BASE + 16'd1, mask); m_w1c(mask);
            test_rx_check("rx_rand_w1c");
        end
    endtask

    task automatic test_overrun_framing();
        set_div(4);
        wr(BASE + 16'd1, 16'h000F); m_w1c(16'h000F);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        test_rx_check("overrun");
        wr(BASE + 16'd1, 16'h000E); m_w1c(16'h000E);
        send(8'h5A, 1'b0);
        test_rx_check("framing");
    endtask

    task automatic test_glitch();
        wr(BASE + 16'd1, 16'h000F); m_w1c(16'h000F);
        for (int d = 2; d <= 4; d += 2) begin
            set_div(d);
            rxd = 1'b0;
            @(negedge clk);
            rxd = 1'b1;
            repeat (12 * d) @(negedge clk);
            test_rx_check("glitch");
        end
    endtask

    task automatic test_set_wins();
        logic [7:0] b;
        int p;
        set_div(int'($urandom_range(2, 6)));
        wr(BASE + 16'd1, 16'h000F); m_w1c(16'h000F);
        b = 8'($urandom);
        p = per();
        fork
            send(b, 1'b1);
            begin
                repeat (2 + p / 2 + 9 * p) @(negedge clk);
                bus.d_addr = BASE + 16'd1; bus.d_din = 16'h0002; bus.d_we = 1'b1;
                m_w1c(16'h0002);
                @(negedge clk);
                bus.d_we = 1'b0;
            end
        join
        test_rx_check("set_wins");
    endtask

    task automatic test_full_duplex();
        set_div(int'($urandom_range(2, 6)));
        wr(BASE + 16'd1, 16'h000F); m_w1c(16'h000F);
        fork
            test_tx(8'($urandom), -1);
            send(8'($urandom), 1'b1);
        join
        test_rx_check("duplex");
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        set_div(6);
        wr(BASE, 16'h005A);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (txd !== 1'b0) begin n_err++; $display("FAIL mid_pre_txd got=%b want=0", txd); end
        rst = 1'b1;
        @(negedge clk);
        m_reset();
        n_cmp++;
        if (txd !== 1'b1) begin n_err++; $display("FAIL mid_rst_txd got=%b want=1", txd); end
        rd(BASE + 16'd1, v);
        n_cmp++;
        if (v !== m_status(1'b0)) begin n_err++; $display("FAIL mid_rst_status got=%h want=%h", v, m_status(1'b0)); end
        rd(BASE + 16'd2, v);
        n_cmp++;
        if (v !== 16'(m_div)) begin n_err++; $display("FAIL mid_rst_div got=%h want=%h", v, 16'(m_div)); end
        rst = 1'b0;
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        test_rx_check("mid_after");
        n_cmp++;
        if (txd !== 1'b1) begin n_err++; $display("FAIL mid_after_txd got=%b want=1", txd); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rxd = 1'b1;
        bus.d_addr = 16'h0; bus.d_din = 16'h0; bus.d_we = 1'b0;
        m_reset();
        test_reset();
        test_tx(8'hA5, -1);
        for (int it = 0; it < 4; it++) begin
            set_div(int'($urandom_range(0, 7)));
            test_tx(8'($urandom), -1);
        end
        set_div(4);
        test_tx(8'h55, 7);
        test_rx();
        test_overrun_framing();
        test_glitch();
        test_set_wins();
        test_full_duplex();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
